seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_LEN, default 7: pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter PATTERN, default 7'b0111110: PAT_LEN-bit target sequence; bit PAT_LEN-1 is the first bit received.
REQ-003 SHALL have parameter CNT_W, default 8: hit counter width, legal range 1..32.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, 1: din is valid this cycle.
REQ-007 SHALL have port din, input, 1: serial data bit.
REQ-008 SHALL have port overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port clr_cnt, input, 1: synchronous clear of hit_cnt.
REQ-010 SHALL have port hit, output, 1: registered one-cycle detection pulse.
REQ-011 SHALL have port hit_cnt, output, CNT_W: saturating count of detections.

Function
REQ-012 SHALL keep a PAT_LEN-1-bit history register, shifted left with din on every cycle with en=1, and held when en=0.
REQ-013 SHALL keep a fill counter in the range 0..PAT_LEN-1 that increments on each en=1 bit and saturates at PAT_LEN-1.
REQ-014 SHALL detect a match on a cycle where en=1, fill=PAT_LEN-1 and {history, din} equals PATTERN.
REQ-015 SHALL assert hit for exactly the one cycle after the edge that samples the final matching bit (1-cycle latency), and deassert it on all other cycles, including cycles with en=0.
REQ-016 SHALL, with overlap=1, leave fill unchanged on a match, so that a suffix of one match can begin the next.
REQ-017 SHALL, with overlap=0, clear fill to 0 on a match, so that the next match requires PAT_LEN fresh bits.
REQ-018 SHALL sample overlap only on the match cycle; a mode change mid-stream affects only subsequent matches.
REQ-019 SHALL increment hit_cnt on each match and saturate it at 2^CNT_W-1 with no wrap.
REQ-020 SHALL, when clr_cnt=1 and a match occur on the same edge, load hit_cnt with 1 so that no hit is lost; clr_cnt alone loads 0.
REQ-021 SHALL treat din as don't-care when en=0.

Reset
REQ-022 SHALL, while rst=1, force history=0, fill=0, hit=0 and hit_cnt=0 asynchronously.
REQ-023 SHALL discard any partial match when rst is asserted mid-sequence; after release, detection requires PAT_LEN new bits.

Configuration
REQ-024 SHALL, when macro SEQDET_HITCNT_EN is defined, implement hit_cnt and clr_cnt as specified in REQ-019 and REQ-020.
REQ-025 SHALL, when SEQDET_HITCNT_EN is undefined, tie hit_cnt to 0, ignore clr_cnt and instantiate no counter flops; hit behaviour is unchanged.

Structure
REQ-026 SHALL place the shared constants in package seq_det_pkg: SEQDET_DEF_LEN=7, SEQDET_DEF_PATTERN=7'b0111110 and SEQDET_DEF_CNT_W=8.
REQ-027 SHALL implement the saturating counter as sub-module seq_det_sat_cnt, with ports clk, rst, clr, inc and count, parametrised by CNT_W.
REQ-028 SHALL reject illegal PAT_LEN or CNT_W values at elaboration.

Verification (defaults, SEQDET_HITCNT_EN defined)
REQ-029 SHALL cover this scenario: reset, then en=1 and din=0,1,1,1,1,1,0 -> hit=1 only in the cycle after the 7th bit; hit_cnt=1.
REQ-030 SHALL cover this scenario: overlap=1, din=0111110111110 -> two hits, after bit 7 and after bit 13; hit_cnt=2.
REQ-031 SHALL cover this scenario: the same stream with overlap=0 -> one hit, after bit 7; hit_cnt=1.
REQ-032 SHALL cover this scenario: bits 0,1,1 with en=1, then en=0 for 5 cycles (din toggling), then 1,1,1,0 with en=1 -> one hit; no hit during the en=0 gap.
REQ-033 SHALL cover this scenario: rst pulsed after bit 4 of a match, then the remaining 3 bits -> no hit; the full 7 bits after reset -> hit.
REQ-034 SHALL cover this scenario: CNT_W=2 with 5 matches -> hit_cnt=3 (saturated); then clr_cnt on the same edge as a match -> hit_cnt=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration helpers for the parametrised serial
// sequence detector.
package seq_det_pkg;

  localparam int         SEQDET_DEF_LEN     = 7;
  localparam logic [6:0] SEQDET_DEF_PATTERN = 7'b0111110;
  localparam int         SEQDET_DEF_CNT_W   = 8;

  localparam int SEQDET_MIN_LEN   = 2;
  localparam int SEQDET_MAX_LEN   = 32;
  localparam int SEQDET_MIN_CNT_W = 1;
  localparam int SEQDET_MAX_CNT_W = 32;

  // True when a pattern length can be built.
  function automatic bit seqdet_len_ok(input int len);
    return (len >= SEQDET_MIN_LEN) && (len <= SEQDET_MAX_LEN);
  endfunction

  // True when a hit counter width can be built.
  function automatic bit seqdet_cnt_w_ok(input int w);
    return (w >= SEQDET_MIN_CNT_W) && (w <= SEQDET_MAX_CNT_W);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear. A clear and an increment
// on the same edge load 1, so the event arriving with the clear is kept.
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int CNT_W = SEQDET_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  generate
    if (!seqdet_cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
      $error("seq_det_sat_cnt: CNT_W must be in 1..32");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Count events, stop at all-ones, clear on request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_ONE : '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with overlapping / non-overlapping
// mode and a registered one-cycle hit pulse.
// Optional feature macro: SEQDET_HITCNT_EN -- when defined, a saturating
// hit counter drives hit_cnt and clr_cnt clears it; when undefined,
// hit_cnt is tied to 0 and clr_cnt is ignored.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = SEQDET_DEF_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = SEQDET_DEF_PATTERN,
  parameter int                 CNT_W   = SEQDET_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt
);

  generate
    if (!seqdet_len_ok(PAT_LEN)) begin : g_bad_len
      $error("seq_detector_param: PAT_LEN must be in 2..32");
    end
    if (!seqdet_cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
      $error("seq_detector_param: CNT_W must be in 1..32");
    end
  endgenerate

  // fill counts valid bits seen, up to PAT_LEN-1; once full, the history
  // plus the incoming bit form a complete candidate window.
  localparam int                FILL_W   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] history;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] window;
  logic               match;

  assign window = {history, din};
  assign match  = en && (fill == FILL_MAX) && (window == PATTERN);

  // Shift in valid bits, track fill, and register the detection pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
      hit     <= 1'b0;
    end else begin
      hit <= match;
      if (en) begin
        history <= window[PAT_LEN-2:0];
        // Non-overlapping mode restarts the fill so the next match needs
        // PAT_LEN fresh bits; overlapping mode keeps the window full.
        if (match && !overlap) begin
          fill <= '0;
        end else if (fill != FILL_MAX) begin
          fill <= fill + FILL_W'(1);
        end
      end
    end
  end

`ifdef SEQDET_HITCNT_EN
  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (match),
    .count (hit_cnt)
  );
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Table-driven bench for seq_detector_param: a default-width instance and a
// CNT_W=2 instance share one stimulus stream; the counter sub-module is
// also exercised on its own.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, en, din, overlap, clr_cnt;
  logic       hit, hit2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  logic       c_clr, c_inc;
  logic [1:0] c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap),
    .clr_cnt(clr_cnt), .hit(hit), .hit_cnt(cnt)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap),
    .clr_cnt(clr_cnt), .hit(hit2), .hit_cnt(cnt2)
  );

  seq_det_sat_cnt #(.CNT_W(2)) u_cnt (
    .clk(clk), .rst(rst), .clr(c_clr), .inc(c_inc), .count(c_cnt)
  );

  typedef struct {
    logic       rst, en, din, ovl, clr, hit;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } vec_t;

  vec_t vq[$];

  function automatic logic [7:0] ec(input logic [7:0] v);
`ifdef SEQDET_HITCNT_EN
    return v;
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic push(input logic r, e, d, o, c, h, input logic [7:0] n, input logic [1:0] n2);
    vec_t v;
    v.rst = r; v.en = e; v.din = d; v.ovl = o; v.clr = c; v.hit = h;
    v.cnt = n; v.cnt2 = n2;
    vq.push_back(v);
  endtask

  // n bits MSB first with en=1; only the last row can hit or clear.
  task automatic push_seq(input logic [15:0] bits, input int n, input logic ovl_pre, ovl_last,
                          input logic clr_last, hit_last, input logic [7:0] cb, ca,
                          input logic [1:0] c2b, c2a);
    for (int i = n - 1; i > 0; i--) push(0, 1, bits[i], ovl_pre, 0, 0, cb, c2b);
    push(0, 1, bits[0], ovl_last, clr_last, hit_last, ca, c2a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; overlap = 1'b1; clr_cnt = 1'b0;
    c_clr = 1'b0; c_inc = 1'b0;

    // Single match from reset, then an idle cycle.
    push_seq(16'b0111110, 7, 1, 1, 0, 1, 0, 1, 0, 1);
    push(0, 0, 1, 1, 0, 0, 1, 1);
    // Overlapping: two hits on 0111110111110.
    push(1, 0, 0, 1, 0, 0, 0, 0);
    push_seq(16'b0111110, 7, 1, 1, 0, 1, 0, 1, 0, 1);
    push_seq(16'b111110, 6, 1, 1, 0, 1, 1, 2, 1, 2);
    // Non-overlapping: same stream, one hit.
    push(1, 0, 0, 1, 0, 0, 0, 0);
    push_seq(16'b0111110, 7, 0, 0, 0, 1, 0, 1, 0, 1);
    push_seq(16'b111110, 6, 0, 0, 0, 0, 1, 1, 1, 1);
    // en=0 gap with toggling din.
    push(1, 0, 0, 1, 0, 0, 0, 0);
    push_seq(16'b011, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) push(0, 0, (i % 2 == 0), 1, 0, 0, 0, 0);
    push_seq(16'b1110, 4, 1, 1, 0, 1, 0, 1, 0, 1);
    // Reset in the middle of a match discards the partial pattern.
    push(1, 0, 0, 1, 0, 0, 0, 0);
    push_seq(16'b0111, 4, 1, 1, 0, 0, 0, 0, 0, 0);
    push(1, 0, 0, 1, 0, 0, 0, 0);
    push_seq(16'b110, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    push_seq(16'b0111110, 7, 1, 1, 0, 1, 0, 1, 0, 1);
    // Overlapping run; overlap low except on the match bit of group 1.
    push_seq(16'b111110, 6, 0, 1, 0, 1, 1, 2, 1, 2);
    push_seq(16'b111110, 6, 1, 1, 0, 1, 2, 3, 2, 3);
    push_seq(16'b111110, 6, 1, 1, 0, 1, 3, 4, 3, 3);
    push_seq(16'b111110, 6, 1, 1, 0, 1, 4, 5, 3, 3);
    // Clear together with a match keeps that match.
    push_seq(16'b111110, 6, 1, 1, 1, 1, 5, 1, 3, 1);
    // Clear alone.
    push(0, 0, 0, 1, 1, 0, 0, 0);
    // Match sampled with overlap=0, so the next six bits cannot match.
    push_seq(16'b111110, 6, 1, 0, 0, 1, 0, 1, 0, 1);
    push_seq(16'b111110, 6, 1, 1, 0, 0, 1, 1, 1, 1);
    push(0, 1, 0, 1, 1, 0, 0, 0);

    // Reset state.
    tick();
    chk("reset_hit", -1, 32'(hit), 32'd0);
    chk("reset_cnt", -1, 32'(cnt), 32'd0);
    chk("reset_hit2", -1, 32'(hit2), 32'd0);
    chk("reset_cnt2", -1, 32'(cnt2), 32'(ec(8'd0)));
    chk("reset_ucnt", -1, 32'(c_cnt), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; en = vq[i].en; din = vq[i].din;
      overlap = vq[i].ovl; clr_cnt = vq[i].clr;
      tick();
      chk("hit", i, 32'(hit), 32'(vq[i].hit));
      chk("hit2", i, 32'(hit2), 32'(vq[i].hit));
      chk("hit_cnt", i, 32'(cnt), 32'(ec(vq[i].cnt)));
      chk("hit_cnt_w2", i, 32'(cnt2), 32'(ec({6'd0, vq[i].cnt2})));
    end

    // Asynchronous reset lands between edges and kills a live hit pulse.
    rst = 1'b0; clr_cnt = 1'b0; overlap = 1'b1; en = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      din = (i != 6) && (i != 0);
      tick();
    end
    chk("async_pre_hit", 100, 32'(hit), 32'd1);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_hit", 101, 32'(hit), 32'd0);
    chk("async_cnt", 101, 32'(cnt), 32'd0);
    chk("async_hit2", 101, 32'(hit2), 32'd0);
    tick();
    rst = 1'b0;

    // Counter sub-module on its own.
    c_inc = 1'b1;
    tick(); chk("ucnt_inc1", 200, 32'(c_cnt), 32'd1);
    tick(); chk("ucnt_inc2", 201, 32'(c_cnt), 32'd2);
    tick(); chk("ucnt_inc3", 202, 32'(c_cnt), 32'd3);
    tick(); chk("ucnt_sat", 203, 32'(c_cnt), 32'd3);
    c_clr = 1'b1;
    tick(); chk("ucnt_clr_inc", 204, 32'(c_cnt), 32'd1);
    c_inc = 1'b0;
    tick(); chk("ucnt_clr", 205, 32'(c_cnt), 32'd0);
    c_clr = 1'b0;
    tick(); chk("ucnt_hold", 206, 32'(c_cnt), 32'd0);
    c_inc = 1'b1;
    tick(); chk("ucnt_inc", 207, 32'(c_cnt), 32'd1);
    #2 rst = 1'b1;
    #1 chk("ucnt_async_rst", 208, 32'(c_cnt), 32'd0);
    rst = 1'b0;
    c_inc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
